mcu_pwm_capture: RTL and testbench
==================================

MCU_PWM_CAPTURE -- requirements
Module: mcu_pwm_capture

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 24: width of period/high-time counters; bytes are exposed MSB first.
REQ-002 SHALL have parameter STAT_ADDR, default 8'h18: address of the status register.
REQ-003 SHALL have port clk  input  1: single clock, rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port pwm_ncs  input  1: MCU bus chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port pwm_nrd  input  1: MCU bus read strobe, active-low, asynchronous to clk.
REQ-007 SHALL have port pwm_addr  input  8: MCU byte address, sampled with the strobes.
REQ-008 SHALL have port pwm_rd_data  output  8: read data to the MCU SRAM data bus.
REQ-009 SHALL have port pwm_rd_oe  output  1: data-bus drive enable, high while a read is active.
REQ-010 SHALL have ports pwmin1..pwmin4  input  1 each: asynchronous PWM inputs to measure.

Function
REQ-011 SHALL pass each pwmin through a 2-flop synchronizer, then through an edge detector on the synchronized value.
REQ-012 SHALL keep one free counter per channel: cleared to 1 on a synchronized rising edge, otherwise +1, saturating at 2^CNT_WIDTH-1.
REQ-013 SHALL, on a falling edge, capture the counter into high_pend (cycles high).
REQ-014 SHALL, on a rising edge following a complete high/low cycle, load period = counter value and high = high_pend into the channel result registers in the same clock.
REQ-015 SHALL set valid[n] on the first result load after reset or timeout; the first rising edge after reset/timeout only starts measurement.
REQ-016 SHALL treat counter saturation as a timeout: set tmo[n], clear valid[n], zero period/high; tmo[n] clears on the next result load.
REQ-017 SHALL sample ncs, nrd and addr with a 2-flop synchronizer; a read starts on the first clock at which sync ncs=0 and nrd=0 after either was high.
REQ-018 SHALL register pwm_rd_data and assert pwm_rd_oe 2 clk after the read start, holding both until sync ncs or nrd goes high; pwm_rd_oe SHALL then drop within 1 clk.
REQ-019 Address map SHALL be: channel n (0..3) base 6n; +0..+2 period[23:16],[15:8],[7:0]; +3..+5 high[23:16],[15:8],[7:0].
REQ-020 STAT_ADDR SHALL read {tmo[3:0], valid[3:0]}; all other addresses SHALL read 8'h00.
REQ-021 A result load coinciding with a read SHALL NOT change pwm_rd_data within that read.
REQ-022 Writes (nwe) SHALL be ignored; the block is read-only.

Reset
REQ-023 While reset=0 at a clk edge: pwm_rd_data=8'h00, pwm_rd_oe=0, all counters, high_pend, period, high, valid and tmo cleared, and synchronizers cleared to idle (ncs/nrd=1, pwmin=0).
REQ-024 Reset asserted mid-read SHALL drop pwm_rd_oe the next clock; a read SHALL start only after ncs/nrd are seen high post-reset.
REQ-025 Reset asserted mid-measurement SHALL discard the partial cycle.

Configuration
REQ-026 Macro PWM_CAPTURE_SNAPSHOT_EN defined: a read of channel offset +0 SHALL copy that channel's period/high into a snapshot, and offsets +1..+5 SHALL read from the snapshot (coherent 6-byte read).
REQ-027 Macro undefined: all offsets SHALL read live result registers; no snapshot storage SHALL be built.

Verification
REQ-028 Reset: reset=0 for 3 clk with pwmin toggling -> pwm_rd_oe=0, pwm_rd_data=00, status reads 00 after release.
REQ-029 pwmin1 period 1000 clk, high 250 clk, three cycles -> addr 0..5 read 00,03,E8,00,00,FA; status bit0=1.
REQ-030 All four channels at distinct periods 400/500/600/700 clk, high 100 clk -> each channel's bytes are correct; status=0F.
REQ-031 pwmin2 held low for more than 2^24 clk after a valid cycle -> status bit5=1, bit1=0, addr 6..11 read 00; next full cycle clears bit5.
REQ-032 With PWM_CAPTURE_SNAPSHOT_EN, channel 1 period changes 0x0000FF->0x000100 between reads of +0 and +2 -> read 00,00,FF; without the macro, the live value is returned.
REQ-033 Read timing: ncs/nrd low -> oe rises exactly 2 clk after sync; unmapped addr 0x30 reads 00; write strobes cause no state change.

Source files
------------

// File: rtl/mcu_pwm_capture_if.sv
// MCU read bus between an external SRAM-style host and mcu_pwm_capture.
interface mcu_pwm_capture_if;
   logic       pwm_ncs;
   logic       pwm_nrd;
   logic [7:0] pwm_addr;
   logic [7:0] pwm_rd_data;
   logic       pwm_rd_oe;

   modport master (
      output pwm_ncs,
      output pwm_nrd,
      output pwm_addr,
      input  pwm_rd_data,
      input  pwm_rd_oe
   );

   modport slave (
      input  pwm_ncs,
      input  pwm_nrd,
      input  pwm_addr,
      output pwm_rd_data,
      output pwm_rd_oe
   );
endinterface

// File: rtl/mcu_pwm_capture.sv
// Four-channel PWM period/high-time capture, read back over an asynchronous
// MCU read bus. Define PWM_CAPTURE_SNAPSHOT_EN to make each channel's 6-byte
// result coherent: reading offset +0 freezes period/high for offsets +1..+5.
// Counters are CNT_WIDTH bits (up to 24) and are exposed as 3 bytes, MSB first.
module mcu_pwm_capture #(
   parameter int unsigned CNT_WIDTH = 24,
   parameter logic [7:0]  STAT_ADDR = 8'h18
) (
   input  logic              clk,
   input  logic              reset,
   mcu_pwm_capture_if.slave  bus,
   input  logic              pwmin1,
   input  logic              pwmin2,
   input  logic              pwmin3,
   input  logic              pwmin4
);

   localparam int unsigned NCH    = 4;
   localparam int unsigned BYTE_W = 24;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_WAIT,
      RD_ACTIVE
   } rd_state_e;

   logic [NCH-1:0]       pwm_in_c;
   logic [NCH-1:0]       in_s1_q, in_s1_d;
   logic [NCH-1:0]       in_s2_q, in_s2_d;
   logic [NCH-1:0]       in_dly_q, in_dly_d;
   logic [NCH-1:0]       rise_c, fall_c;

   logic [CNT_WIDTH-1:0] cnt_q       [NCH];
   logic [CNT_WIDTH-1:0] cnt_d       [NCH];
   logic [CNT_WIDTH-1:0] high_pend_q [NCH];
   logic [CNT_WIDTH-1:0] high_pend_d [NCH];
   logic [CNT_WIDTH-1:0] period_q    [NCH];
   logic [CNT_WIDTH-1:0] period_d    [NCH];
   logic [CNT_WIDTH-1:0] high_q      [NCH];
   logic [CNT_WIDTH-1:0] high_d      [NCH];
   logic [NCH-1:0]       started_q, started_d;
   logic [NCH-1:0]       fell_q, fell_d;
   logic [NCH-1:0]       valid_q, valid_d;
   logic [NCH-1:0]       tmo_q, tmo_d;

   logic                 ncs_s1_q, ncs_s1_d, ncs_s2_q, ncs_s2_d;
   logic                 nrd_s1_q, nrd_s1_d, nrd_s2_q, nrd_s2_d;
   logic [7:0]           addr_s1_q, addr_s1_d, addr_s2_q, addr_s2_d;
   logic [1:0]           fill_q, fill_d;
   logic                 armed_q, armed_d;
   rd_state_e            rd_state_q, rd_state_d;
   logic [7:0]           rd_data_q, rd_data_d;
   logic                 rd_oe_q, rd_oe_d;

   logic                 sel_c;
   logic                 idle_seen_c;
   logic [7:0]           rd_byte_c;
   logic [7:0]           off_c;
   logic [BYTE_W-1:0]    src_p_c;
   logic [BYTE_W-1:0]    src_h_c;

`ifdef PWM_CAPTURE_SNAPSHOT_EN
   logic [CNT_WIDTH-1:0] snap_period_q [NCH];
   logic [CNT_WIDTH-1:0] snap_period_d [NCH];
   logic [CNT_WIDTH-1:0] snap_high_q   [NCH];
   logic [CNT_WIDTH-1:0] snap_high_d   [NCH];
   logic [NCH-1:0]       snap_hit_c;
`endif

   assign pwm_in_c = {pwmin4, pwmin3, pwmin2, pwmin1};
   assign rise_c   = in_s2_q & ~in_dly_q;
   assign fall_c   = ~in_s2_q & in_dly_q;

   assign bus.pwm_rd_data = rd_data_q;
   assign bus.pwm_rd_oe   = rd_oe_q;

   // Per-channel synchronizer feed, free counter and period/high measurement.
   always_comb begin
      in_s1_d   = pwm_in_c;
      in_s2_d   = in_s1_q;
      in_dly_d  = in_s2_q;
      started_d = started_q;
      fell_d    = fell_q;
      valid_d   = valid_q;
      tmo_d     = tmo_q;
      for (int n = 0; n < NCH; n++) begin
         cnt_d[n]       = cnt_q[n];
         high_pend_d[n] = high_pend_q[n];
         period_d[n]    = period_q[n];
         high_d[n]      = high_q[n];
         if (rise_c[n]) begin
            cnt_d[n]     = CNT_WIDTH'(1);
            started_d[n] = 1'b1;
            fell_d[n]    = 1'b0;
            if (cnt_q[n] == CNT_MAX) begin
               // Saturated counter on this edge: the cycle was too long to trust.
               tmo_d[n]    = 1'b1;
               valid_d[n]  = 1'b0;
               period_d[n] = '0;
               high_d[n]   = '0;
            end else if (started_q[n] && fell_q[n]) begin
               period_d[n] = cnt_q[n];
               high_d[n]   = high_pend_q[n];
               valid_d[n]  = 1'b1;
               tmo_d[n]    = 1'b0;
            end
         end else if (cnt_q[n] == CNT_MAX) begin
            // Timeout: drop results and restart measurement from the next rising edge.
            tmo_d[n]     = 1'b1;
            valid_d[n]   = 1'b0;
            period_d[n]  = '0;
            high_d[n]    = '0;
            started_d[n] = 1'b0;
            fell_d[n]    = 1'b0;
         end else begin
            cnt_d[n] = cnt_q[n] + CNT_WIDTH'(1);
            if (fall_c[n] && started_q[n]) begin
               high_pend_d[n] = cnt_q[n];
               fell_d[n]      = 1'b1;
            end
         end
      end
   end

   // Read data mux: channel result bytes MSB first, status byte, zero elsewhere.
   always_comb begin
      rd_byte_c = '0;
      off_c     = '0;
      src_p_c   = '0;
      src_h_c   = '0;
`ifdef PWM_CAPTURE_SNAPSHOT_EN
      snap_hit_c = '0;
`endif
      for (int n = 0; n < NCH; n++) begin
         if (addr_s2_q >= 8'(6 * n) && addr_s2_q < 8'(6 * n + 6)) begin
            off_c   = addr_s2_q - 8'(6 * n);
            src_p_c = BYTE_W'(period_q[n]);
            src_h_c = BYTE_W'(high_q[n]);
`ifdef PWM_CAPTURE_SNAPSHOT_EN
            if (off_c == 8'd0) begin
               snap_hit_c[n] = 1'b1;
            end else begin
               src_p_c = BYTE_W'(snap_period_q[n]);
               src_h_c = BYTE_W'(snap_high_q[n]);
            end
`endif
            case (off_c)
               8'd0:    rd_byte_c = src_p_c[23:16];
               8'd1:    rd_byte_c = src_p_c[15:8];
               8'd2:    rd_byte_c = src_p_c[7:0];
               8'd3:    rd_byte_c = src_h_c[23:16];
               8'd4:    rd_byte_c = src_h_c[15:8];
               default: rd_byte_c = src_h_c[7:0];
            endcase
         end
      end
      if (addr_s2_q == STAT_ADDR) begin
         rd_byte_c = {tmo_q, valid_q};
      end
   end

`ifdef PWM_CAPTURE_SNAPSHOT_EN
   // Freeze a channel's results when its +0 byte is latched onto the bus.
   always_comb begin
      for (int n = 0; n < NCH; n++) begin
         snap_period_d[n] = snap_period_q[n];
         snap_high_d[n]   = snap_high_q[n];
         if (rd_state_q == RD_WAIT && sel_c && snap_hit_c[n]) begin
            snap_period_d[n] = period_q[n];
            snap_high_d[n]   = high_q[n];
         end
      end
   end
`endif

   // Bus synchronizers and read sequencer; data is latched once per read.
   always_comb begin
      ncs_s1_d  = bus.pwm_ncs;
      ncs_s2_d  = ncs_s1_q;
      nrd_s1_d  = bus.pwm_nrd;
      nrd_s2_d  = nrd_s1_q;
      addr_s1_d = bus.pwm_addr;
      addr_s2_d = addr_s1_q;
      fill_d    = {fill_q[0], 1'b1};

      // fill_q hides the reset-forced idle levels until real samples arrive.
      sel_c       = !ncs_s2_q && !nrd_s2_q;
      idle_seen_c = fill_q[1] && (ncs_s2_q || nrd_s2_q);

      armed_d    = armed_q;
      rd_state_d = rd_state_q;
      rd_data_d  = rd_data_q;
      rd_oe_d    = rd_oe_q;

      case (rd_state_q)
         RD_IDLE: begin
            rd_oe_d = 1'b0;
            if (idle_seen_c) begin
               armed_d = 1'b1;
            end else if (armed_q && fill_q[1] && sel_c) begin
               armed_d    = 1'b0;
               rd_state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (!sel_c) begin
               rd_state_d = RD_IDLE;
               armed_d    = 1'b1;
            end else begin
               rd_state_d = RD_ACTIVE;
               rd_data_d  = rd_byte_c;
               rd_oe_d    = 1'b1;
            end
         end
         RD_ACTIVE: begin
            if (!sel_c) begin
               rd_state_d = RD_IDLE;
               rd_oe_d    = 1'b0;
               armed_d    = 1'b1;
            end
         end
         default: begin
            rd_state_d = RD_IDLE;
            rd_oe_d    = 1'b0;
         end
      endcase
   end

   // All state, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_s1_q    <= '0;
         in_s2_q    <= '0;
         in_dly_q   <= '0;
         started_q  <= '0;
         fell_q     <= '0;
         valid_q    <= '0;
         tmo_q      <= '0;
         for (int n = 0; n < NCH; n++) begin
            cnt_q[n]       <= '0;
            high_pend_q[n] <= '0;
            period_q[n]    <= '0;
            high_q[n]      <= '0;
`ifdef PWM_CAPTURE_SNAPSHOT_EN
            snap_period_q[n] <= '0;
            snap_high_q[n]   <= '0;
`endif
         end
         ncs_s1_q   <= 1'b1;
         ncs_s2_q   <= 1'b1;
         nrd_s1_q   <= 1'b1;
         nrd_s2_q   <= 1'b1;
         addr_s1_q  <= '0;
         addr_s2_q  <= '0;
         fill_q     <= '0;
         armed_q    <= 1'b0;
         rd_state_q <= RD_IDLE;
         rd_data_q  <= '0;
         rd_oe_q    <= 1'b0;
      end else begin
         in_s1_q    <= in_s1_d;
         in_s2_q    <= in_s2_d;
         in_dly_q   <= in_dly_d;
         started_q  <= started_d;
         fell_q     <= fell_d;
         valid_q    <= valid_d;
         tmo_q      <= tmo_d;
         for (int n = 0; n < NCH; n++) begin
            cnt_q[n]       <= cnt_d[n];
            high_pend_q[n] <= high_pend_d[n];
            period_q[n]    <= period_d[n];
            high_q[n]      <= high_d[n];
`ifdef PWM_CAPTURE_SNAPSHOT_EN
            snap_period_q[n] <= snap_period_d[n];
            snap_high_q[n]   <= snap_high_d[n];
`endif
         end
         ncs_s1_q   <= ncs_s1_d;
         ncs_s2_q   <= ncs_s2_d;
         nrd_s1_q   <= nrd_s1_d;
         nrd_s2_q   <= nrd_s2_d;
         addr_s1_q  <= addr_s1_d;
         addr_s2_q  <= addr_s2_d;
         fill_q     <= fill_d;
         armed_q    <= armed_d;
         rd_state_q <= rd_state_d;
         rd_data_q  <= rd_data_d;
         rd_oe_q    <= rd_oe_d;
      end
   end

endmodule

// File: tb/tb_mcu_pwm_capture.sv
// Directed bench for mcu_pwm_capture. Counters are narrowed to 12 bits so the
// saturation timeout is reachable in a few thousand clocks.
module tb_mcu_pwm_capture;

   localparam int unsigned CW   = 12;
   localparam logic [7:0]  STAT = 8'h18;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] pwm = '0;

   int  per [4];
   int  hi  [4];
   int  ph  [4];
   bit  en  [4];

   int  n_vec = 0;
   int  n_err = 0;

   mcu_pwm_capture_if bus ();

   mcu_pwm_capture #(
      .CNT_WIDTH (CW),
      .STAT_ADDR (STAT)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus.slave),
      .pwmin1 (pwm[0]),
      .pwmin2 (pwm[1]),
      .pwmin3 (pwm[2]),
      .pwmin4 (pwm[3])
   );

   always #5 clk = ~clk;

   // PWM sources: each enabled channel is high for hi[] of every per[] clocks.
   initial begin
      for (int i = 0; i < 4; i++) begin
         per[i] = 10; hi[i] = 5; ph[i] = 0; en[i] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (!en[i]) begin
               pwm[i] = 1'b0;
               ph[i]  = 0;
            end else begin
               pwm[i] = (ph[i] < hi[i]);
               ph[i]  = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // One bus read; lat is the number of clocks from strobe assertion to oe.
   task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output int lat);
      int n;
      @(negedge clk);
      bus.pwm_addr = a;
      bus.pwm_ncs  = 1'b0;
      bus.pwm_nrd  = 1'b0;
      lat = -1;
      n   = 0;
      while (n < 20 && lat < 0) begin
         @(negedge clk);
         n++;
         if (bus.pwm_rd_oe === 1'b1) lat = n;
      end
      d = bus.pwm_rd_data;
      if (lat < 0) begin
         n_vec++; n_err++;
         $display("FAIL read_oe_timeout addr=%02h: oe never rose", a);
      end
      bus.pwm_ncs = 1'b1;
      bus.pwm_nrd = 1'b1;
      n = 0;
      while (bus.pwm_rd_oe !== 1'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] d;
      int         lat;
      for (int i = 0; i < 4; i++) begin
         per[i] = 6; hi[i] = 3; en[i] = 1'b1;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_vec++;
         if (bus.pwm_rd_oe !== 1'b0 || bus.pwm_rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: oe=%b data=%02h, want oe=0 data=00",
                     bus.pwm_rd_oe, bus.pwm_rd_data);
         end
      end
      for (int i = 0; i < 4; i++) en[i] = 1'b0;
      reset = 1'b1;
      repeat (5) @(negedge clk);
      bus_read(STAT, d, lat);
      n_vec++;
      if (d !== 8'h00) begin
         n_err++;
         $display("FAIL reset_status: got %02h want 00", d);
      end
   endtask

   task automatic test_single();
      logic [7:0] d;
      int         lat;
      logic [7:0] exp_b [6];
      exp_b = '{8'h00, 8'h03, 8'hE8, 8'h00, 8'h00, 8'hFA};
      do_reset();
      per[0] = 1000; hi[0] = 250; en[0] = 1'b1;
      repeat (3050) @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         bus_read(8'(k), d, lat);
         n_vec++;
         if (d !== exp_b[k]) begin
            n_err++;
            $display("FAIL single_ch0 addr=%0d: got %02h want %02h", k, d, exp_b[k]);
         end
      end
      bus_read(STAT, d, lat);
      n_vec++;
      if (d !== 8'h01) begin
         n_err++;
         $display("FAIL single_status: got %02h want 01", d);
      end
   endtask

   task automatic test_four_channels();
      logic [7:0] d;
      int         lat;
      logic [7:0] exp_b [24];
      exp_b = '{8'h00, 8'h01, 8'h90, 8'h00, 8'h00, 8'h64,
                8'h00, 8'h01, 8'hF4, 8'h00, 8'h00, 8'h64,
                8'h00, 8'h02, 8'h58, 8'h00, 8'h00, 8'h64,
                8'h00, 8'h02, 8'hBC, 8'h00, 8'h00, 8'h64};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         per[i] = 400 + 100 * i; hi[i] = 100; en[i] = 1'b1;
      end
      repeat (2200) @(negedge clk);
      for (int k = 0; k < 24; k++) begin
         bus_read(8'(k), d, lat);
         n_vec++;
         if (d !== exp_b[k]) begin
            n_err++;
            $display("FAIL four_ch addr=%0d: got %02h want %02h", k, d, exp_b[k]);
         end
      end
      bus_read(STAT, d, lat);
      n_vec++;
      if (d !== 8'h0F) begin
         n_err++;
         $display("FAIL four_status: got %02h want 0F", d);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] d;
      int         lat;
      logic [7:0] exp_b [3];
      en[1] = 1'b0;
      repeat (4300) @(negedge clk);
      bus_read(STAT, d, lat);
      n_vec++;
      if (d !== 8'h2D) begin
         n_err++;
         $display("FAIL timeout_status: got %02h want 2D", d);
      end
      for (int k = 6; k < 12; k++) begin
         bus_read(8'(k), d, lat);
         n_vec++;
         if (d !== 8'h00) begin
            n_err++;
            $display("FAIL timeout_zero addr=%0d: got %02h want 00", k, d);
         end
      end
      per[1] = 300; hi[1] = 100; en[1] = 1'b1;
      repeat (700) @(negedge clk);
      bus_read(STAT, d, lat);
      n_vec++;
      if (d !== 8'h0F) begin
         n_err++;
         $display("FAIL timeout_recover_status: got %02h want 0F", d);
      end
      exp_b = '{8'h00, 8'h01, 8'h2C};
      for (int k = 0; k < 3; k++) begin
         bus_read(8'(6 + k), d, lat);
         n_vec++;
         if (d !== exp_b[k]) begin
            n_err++;
            $display("FAIL timeout_recover addr=%0d: got %02h want %02h", 6 + k, d, exp_b[k]);
         end
      end
   endtask

   task automatic test_snapshot();
      logic [7:0] d;
      int         lat;
      logic [7:0] e1, e2;
`ifdef PWM_CAPTURE_SNAPSHOT_EN
      e1 = 8'h00; e2 = 8'hFF;
`else
      e1 = 8'h01; e2 = 8'h00;
`endif
      per[1] = 255;
      repeat (800) @(negedge clk);
      bus_read(8'd6, d, lat);
      n_vec++;
      if (d !== 8'h00) begin
         n_err++;
         $display("FAIL snap_byte0: got %02h want 00", d);
      end
      per[1] = 256;
      repeat (800) @(negedge clk);
      bus_read(8'd7, d, lat);
      n_vec++;
      if (d !== e1) begin
         n_err++;
         $display("FAIL snap_byte1: got %02h want %02h", d, e1);
      end
      bus_read(8'd8, d, lat);
      n_vec++;
      if (d !== e2) begin
         n_err++;
         $display("FAIL snap_byte2: got %02h want %02h", d, e2);
      end
   endtask

   task automatic test_read_timing();
      logic [7:0] d;
      int         lat;
      bit         oe_seen;
      bus_read(STAT, d, lat);
      n_vec++;
      if (lat !== 4) begin
         n_err++;
         $display("FAIL read_latency: got %0d clk want 4", lat);
      end
      bus_read(8'h30, d, lat);
      n_vec++;
      if (d !== 8'h00) begin
         n_err++;
         $display("FAIL unmapped_30: got %02h want 00", d);
      end
      bus_read(8'h19, d, lat);
      n_vec++;
      if (d !== 8'h00) begin
         n_err++;
         $display("FAIL unmapped_19: got %02h want 00", d);
      end
      // Write-style cycle: chip select with read strobe high.
      @(negedge clk);
      bus.pwm_addr = 8'h00;
      bus.pwm_ncs  = 1'b0;
      oe_seen      = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.pwm_rd_oe !== 1'b0) oe_seen = 1'b1;
      end
      bus.pwm_ncs = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if (oe_seen) begin
         n_err++;
         $display("FAIL write_cycle_oe: got oe=1 want 0");
      end
      bus_read(STAT, d, lat);
      n_vec++;
      if (d !== 8'h0F) begin
         n_err++;
         $display("FAIL write_cycle_status: got %02h want 0F", d);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] d;
      int         lat;
      int         n;
      bit         oe_seen;
      for (int i = 0; i < 4; i++) en[i] = 1'b0;
      @(negedge clk);
      bus.pwm_addr = STAT;
      bus.pwm_ncs  = 1'b0;
      bus.pwm_nrd  = 1'b0;
      n = 0;
      while (bus.pwm_rd_oe !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_vec++;
      if (bus.pwm_rd_oe !== 1'b1) begin
         n_err++;
         $display("FAIL midread_oe_rise: got %b want 1", bus.pwm_rd_oe);
      end
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.pwm_rd_oe !== 1'b0 || bus.pwm_rd_data !== 8'h00) begin
         n_err++;
         $display("FAIL midread_reset: oe=%b data=%02h want oe=0 data=00",
                  bus.pwm_rd_oe, bus.pwm_rd_data);
      end
      @(negedge clk);
      reset = 1'b1;
      oe_seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.pwm_rd_oe !== 1'b0) oe_seen = 1'b1;
      end
      n_vec++;
      if (oe_seen) begin
         n_err++;
         $display("FAIL midread_no_restart: got oe=1 want 0");
      end
      bus.pwm_ncs = 1'b1;
      bus.pwm_nrd = 1'b1;
      repeat (4) @(negedge clk);
      bus_read(STAT, d, lat);
      n_vec++;
      if (d !== 8'h00) begin
         n_err++;
         $display("FAIL midread_status: got %02h want 00", d);
      end
   endtask

   initial begin
      bus.pwm_ncs  = 1'b1;
      bus.pwm_nrd  = 1'b1;
      bus.pwm_addr = 8'h00;
      test_reset();
      test_single();
      test_four_channels();
      test_timeout();
      test_snapshot();
      test_read_timing();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
